// File: rtl/bias_act.sv
// rtl/bias_act.sv - bias add, saturate and piecewise-linear activation over a packed vector
// Takes the dot-product result on dataReady and returns the activated vector with a one-cycle outValid.
module bias_act #(
  parameter int NROW           = 16,
  parameter int QN             = 6,
  parameter int QM             = 11,
  parameter int BITWIDTH       = QN + QM + 1,
  parameter int LAYER_BITWIDTH = BITWIDTH * NROW
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dataReady,
  input  logic [LAYER_BITWIDTH-1:0] inputVector,
  input  logic [LAYER_BITWIDTH-1:0] biasVector,
  input  logic [1:0]                actSel,
  output logic [LAYER_BITWIDTH-1:0] outputVector,
  output logic                      outValid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int IW = (NROW > 1) ? $clog2(NROW) : 1;

  localparam logic signed [BITWIDTH-1:0] MAXV    = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [BITWIDTH-1:0] MINV    = {1'b1, {(BITWIDTH-1){1'b0}}};
  localparam logic signed [BITWIDTH-1:0] ONE_N   = BITWIDTH'(1 << QM);
  localparam logic signed [BITWIDTH-1:0] NEG_ONE = -ONE_N;
  localparam logic signed [BITWIDTH:0]   ONE_W   = (BITWIDTH+1)'(1 << QM);
  localparam logic signed [BITWIDTH:0]   HALF_W  = (BITWIDTH+1)'(1 << (QM - 1));

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                      state, state_next;
  logic [LAYER_BITWIDTH-1:0]   in_reg, bias_reg, stage_reg, stage_next;
  logic [1:0]                  act_reg;
  logic [IW-1:0]               idx;
  logic                        last, start;

  logic signed [BITWIDTH-1:0]  x, b, sat, y;
  logic signed [BITWIDTH:0]    s, ext, sig;

  assign last     = (idx == IW'(NROW - 1));
  assign start    = dataReady && (state != CALC);
  assign outValid = (state == DONE);
  assign busy     = (state == CALC);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dataReady) state_next = CALC;
      CALC:    if (last) state_next = DONE;
      DONE:    state_next = dataReady ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One element per cycle; the sum is one bit wider so overflow shows as a sign-bit disagreement.
  always_comb begin
    x   = in_reg[idx*BITWIDTH +: BITWIDTH];
    b   = bias_reg[idx*BITWIDTH +: BITWIDTH];
    s   = {x[BITWIDTH-1], x} + {b[BITWIDTH-1], b};
    if (s[BITWIDTH] != s[BITWIDTH-1]) sat = s[BITWIDTH] ? MINV : MAXV;
    else                              sat = s[BITWIDTH-1:0];
    ext = {sat[BITWIDTH-1], sat};
    sig = (ext >>> 2) + HALF_W;
    case (act_reg)
      2'd0: y = sat;
      2'd1: begin
        if (sig < 0)          y = '0;
        else if (sig > ONE_W) y = ONE_N;
        else                  y = sig[BITWIDTH-1:0];
      end
      2'd2: begin
        if (sat > ONE_N)        y = ONE_N;
        else if (sat < NEG_ONE) y = NEG_ONE;
        else                    y = sat;
      end
      default: y = sat[BITWIDTH-1] ? '0 : sat;
    endcase
    stage_next = stage_reg;
    stage_next[idx*BITWIDTH +: BITWIDTH] = y;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      in_reg       <= '0;
      bias_reg     <= '0;
      act_reg      <= '0;
      stage_reg    <= '0;
      outputVector <= '0;
      overrun      <= 1'b0;
    end else begin
      state <= state_next;
      if (start) begin
        in_reg   <= inputVector;
        bias_reg <= biasVector;
        act_reg  <= actSel;
        idx      <= '0;
      end else if (state == CALC) begin
        stage_reg <= stage_next;
        // The final element goes straight into the output so it updates on the edge entering DONE.
        if (last) outputVector <= stage_next;
        else      idx <= idx + 1'b1;
      end
      if (dataReady && (state == CALC)) overrun <= 1'b1;
    end
  end

endmodule
